// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller for a 5-stage pipeline (EX and MEM producer slots).
// Optional build macro FWD_X2X_EN enables EX-to-EX forwarding from the EX-stage slot.
`timescale 1ns/1ps

module fwd_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idValid,
  input  logic [2:0]  idSrcA,
  input  logic        idSrcAVld,
  input  logic [2:0]  idSrcB,
  input  logic        idSrcBVld,
  input  logic        idDstWr,
  input  logic [2:0]  idDst,
  input  logic [1:0]  idWbSel,
  input  logic        idIsStore,
  input  logic        freeze,
  input  logic        flush,
  output logic [4:0]  fwCntrlA,
  output logic [4:0]  fwCntrlB,
  output logic        stall,
  output logic [15:0] stallCnt
);

  typedef struct packed {
    logic       vld;
    logic       dst_wr;
    logic [2:0] dst;
    logic [1:0] wb_sel;
  } slot_t;

  localparam logic [1:0]  WB_MEM  = 2'b01;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  slot_t       s1_q, s1_d;  // producer in EX
  slot_t       s2_q, s2_d;  // producer in MEM
  logic [4:0]  fw_a_q, fw_a_d;
  logic [4:0]  fw_b_q, fw_b_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic       a_m1, a_m2, b_m1, b_m2;
  logic       s1_hazard;
  logic       take;
  logic [3:0] word_a, word_b;

  function automatic logic src_match(input slot_t s, input logic [2:0] src, input logic src_vld);
    return src_vld & s.vld & s.dst_wr & (s.dst == src);
  endfunction

  // S1 wins over S2 because it holds the youngest write to the register.
  function automatic logic [3:0] fw_word(input logic m1, input logic m2, input logic hazard,
                                         input slot_t s1, input slot_t s2);
    logic [3:0] w;
    w = 4'b0000;
    if (m1) begin
      if (!hazard) w = {1'b1, 1'b0, s1.wb_sel};
    end else if (m2) begin
      w = {1'b1, 1'b1, s2.wb_sel};
    end
    return w;
  endfunction

  always_comb begin
    a_m1 = src_match(s1_q, idSrcA, idSrcAVld);
    a_m2 = src_match(s2_q, idSrcA, idSrcAVld);
    b_m1 = src_match(s1_q, idSrcB, idSrcBVld);
    b_m2 = src_match(s2_q, idSrcB, idSrcBVld);
`ifdef FWD_X2X_EN
    s1_hazard = (s1_q.wb_sel == WB_MEM);
`else
    s1_hazard = 1'b1;
`endif
    stall  = idValid & ~flush & (a_m1 | b_m1) & s1_hazard;
    take   = idValid & ~stall & ~flush;
    word_a = fw_word(a_m1, a_m2, s1_hazard, s1_q, s2_q);
    word_b = fw_word(b_m1, b_m2, s1_hazard, s1_q, s2_q);
  end

  // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    s1_d        = s1_q;
    s2_d        = s2_q;
    fw_a_d      = fw_a_q;
    fw_b_d      = fw_b_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      s2_d = s1_q;
      if (take) begin
        s1_d   = '{vld: 1'b1, dst_wr: idDstWr, dst: idDst, wb_sel: idWbSel};
        fw_a_d = {1'b0, word_a};
        fw_b_d = {idIsStore & idSrcBVld & word_b[3], word_b};
      end else begin
        s1_d   = '0;
        fw_a_d = 5'b00000;
        fw_b_d = 5'b00000;
      end
      if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // NOTE: state uses non-blocking assignments only; whole slots are cleared so stale producers never match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      fw_a_q      <= 5'b00000;
      fw_b_q      <= 5'b00000;
      stall_cnt_q <= 16'h0000;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      fw_a_q      <= fw_a_d;
      fw_b_q      <= fw_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwCntrlA = fw_a_q;
  assign fwCntrlB = fw_b_q;
  assign stallCnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; expectations follow the FWD_X2X_EN build setting.
`timescale 1ns/1ps

module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        idValid, idSrcAVld, idSrcBVld, idDstWr, idIsStore, freeze, flush;
  logic [2:0]  idSrcA, idSrcB, idDst;
  logic [1:0]  idWbSel;
  logic [4:0]  fwCntrlA, fwCntrlB;
  logic        stall;
  logic [15:0] stallCnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt;

  fwd_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .idValid(idValid), .idSrcA(idSrcA), .idSrcAVld(idSrcAVld),
    .idSrcB(idSrcB), .idSrcBVld(idSrcBVld),
    .idDstWr(idDstWr), .idDst(idDst), .idWbSel(idWbSel), .idIsStore(idIsStore),
    .freeze(freeze), .flush(flush),
    .fwCntrlA(fwCntrlA), .fwCntrlB(fwCntrlB), .stall(stall), .stallCnt(stallCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_fa(input string tag, input logic [4:0] exp);
    check(tag, 16'(fwCntrlA), 16'(exp));
  endtask

  task automatic chk_fb(input string tag, input logic [4:0] exp);
    check(tag, 16'(fwCntrlB), 16'(exp));
  endtask

  task automatic chk_st(input string tag, input logic exp);
    check(tag, 16'(stall), 16'(exp));
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    check(tag, stallCnt, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic v, input logic [2:0] sa, input logic sav,
                    input logic [2:0] sb, input logic sbv, input logic dw,
                    input logic [2:0] d, input logic [1:0] wb, input logic st);
    idValid = v;  idSrcA = sa; idSrcAVld = sav; idSrcB = sb; idSrcBVld = sbv;
    idDstWr = dw; idDst = d;   idWbSel = wb;    idIsStore = st;
  endtask

  task automatic drain();
    id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 2'b00, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0; freeze = 1'b0; flush = 1'b0; exp_cnt = 16'd0;
    id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 2'b00, 1'b0);
    #3;
    chk_fa("rst_fwA", 5'b00000);
    chk_fb("rst_fwB", 5'b00000);
    chk_cnt("rst_cnt", 16'd0);
    chk_st("rst_stall", 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD r3 <- r3 + r3 right after reset: slots empty, no stall
    id(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 3'd3, 2'b10, 1'b0);
    #1 chk_st("post_rst_stall", 1'b0);
    tick();
    chk_fa("add_fwA", 5'b00000);
    // consumer reads r3 on A; B names r3 but is not a valid source
    id(1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 1'b1, 3'd6, 2'b10, 1'b0);
    #1;
`ifdef FWD_X2X_EN
    chk_st("x2x_stall", 1'b0);
    tick();
    chk_fa("x2x_fwA", 5'b01010);
    chk_fb("x2x_fwB", 5'b00000);
`else
    chk_st("x2x_stall", 1'b1);
    tick();
    exp_cnt++;
    chk_fa("x2x_bubble_fwA", 5'b00000);
    chk_cnt("x2x_cnt", exp_cnt);
    #1 chk_st("x2x_stall_clr", 1'b0);
    tick();
    chk_fa("x2x_fwA", 5'b01110);
    chk_fb("x2x_fwB", 5'b00000);
`endif
    drain();
    chk_fa("drain_fwA", 5'b00000);

    // load-use on B, with a frozen stall in the middle
    id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 2'b01, 1'b0);
    tick();
    id(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 3'd7, 2'b10, 1'b0);
    #1 chk_st("ld_stall", 1'b1);
    freeze = 1'b1;
    tick();
    tick();
    chk_st("ld_frz_stall", 1'b1);
    chk_cnt("ld_frz_cnt", exp_cnt);
    freeze = 1'b0;
    tick();
    exp_cnt++;
    chk_cnt("ld_cnt", exp_cnt);
    chk_fb("ld_bubble_fwB", 5'b00000);
    chk_st("ld_stall_clr", 1'b0);
    tick();
    chk_fb("ld_fwB", 5'b01101);
    chk_fa("ld_fwA", 5'b00000);
    chk_cnt("ld_cnt_hold", exp_cnt);
    drain();

    // store data r5 produced two ahead by LBI; filler names r5 but does not write it
    id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 2'b11, 1'b0);
    tick();
    id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, 2'b10, 1'b0);
    tick();
    id(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 2'b00, 1'b1);
    #1 chk_st("st_stall", 1'b0);
    tick();
    chk_fb("st_fwB", 5'b11111);
    chk_fa("st_fwA", 5'b00000);
    id(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 2'b00, 1'b1);
    tick();
    chk_fb("st_nofwd_fwB", 5'b00000);
    drain();

    // r4 written by a load (older) and an ALU op (younger)
    id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 2'b01, 1'b0);
    tick();
    id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 2'b10, 1'b0);
    #1 chk_st("pri_prod_stall", 1'b0);
    tick();
    id(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 2'b10, 1'b0);
    #1;
`ifdef FWD_X2X_EN
    chk_st("pri_stall", 1'b0);
    tick();
    chk_fa("pri_fwA", 5'b01010);
`else
    chk_st("pri_stall", 1'b1);
    tick();
    exp_cnt++;
    chk_cnt("pri_cnt", exp_cnt);
    chk_fa("pri_bubble_fwA", 5'b00000);
    tick();
    chk_fa("pri_fwA", 5'b01110);
`endif
    drain();

    // load-use squashed by flush in the same cycle
    id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 2'b01, 1'b0);
    tick();
    id(1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 3'd7, 2'b10, 1'b0);
    #1 chk_st("novalid_stall", 1'b0);
    idValid = 1'b1;
    flush = 1'b1;
    #1 chk_st("flush_stall", 1'b0);
    tick();
    flush = 1'b0;
    chk_fa("flush_fwA", 5'b00000);
    chk_fb("flush_fwB", 5'b00000);
    chk_cnt("flush_cnt", exp_cnt);
    id(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 2'b00, 1'b0);
    #1 chk_st("flushed_prod_stall", 1'b0);
    tick();
    chk_fa("flushed_prod_fwA", 5'b00000);
    drain();

    // freeze and flush together hold all state
    id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 2'b10, 1'b0);
    tick();
    id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 2'b00, 1'b0);
    tick();
    id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd6, 2'b10, 1'b0);
    #1 chk_st("frz_pre_stall", 1'b0);
    tick();
    chk_fa("frz_pre_fwA", 5'b01110);
    id(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 2'b10, 1'b0);
    freeze = 1'b1;
    flush = 1'b1;
    #1 chk_st("frz_flush_stall", 1'b0);
    tick();
    tick();
    chk_fa("frz_hold_fwA", 5'b01110);
    chk_cnt("frz_hold_cnt", exp_cnt);
    freeze = 1'b0;
    flush = 1'b0;
    #1;
`ifdef FWD_X2X_EN
    chk_st("unfrz_stall", 1'b0);
    tick();
    chk_fa("unfrz_fwA", 5'b01010);
`else
    chk_st("unfrz_stall", 1'b1);
    tick();
    exp_cnt++;
    chk_cnt("unfrz_cnt", exp_cnt);
    chk_fa("unfrz_bubble_fwA", 5'b00000);
    tick();
    chk_fa("unfrz_fwA", 5'b01110);
`endif
    drain();

    // reset mid-stream with a pending S1 match
    id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 2'b11, 1'b0);
    tick();
    id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 2'b00, 1'b0);
    tick();
    id(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b1, 3'd3, 2'b10, 1'b0);
    tick();
    chk_fa("prerst_fwA", 5'b01111);
    chk_cnt("prerst_cnt", exp_cnt);
    id(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 3'd1, 2'b10, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    chk_fa("midrst_fwA", 5'b00000);
    chk_fb("midrst_fwB", 5'b00000);
    chk_cnt("midrst_cnt", exp_cnt);
    chk_st("midrst_stall", 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk_st("postrst_stall", 1'b0);
    tick();
    chk_fa("postrst_fwA", 5'b00000);
    chk_fb("postrst_fwB", 5'b00000);
    chk_cnt("postrst_cnt", exp_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have inputs idValid (1), idSrcA (3), idSrcAVld (1), idSrcB (3), idSrcBVld (1): decode-stage instruction and its source registers.
REQ-004 SHALL have inputs idDstWr (1), idDst (3), idWbSel (2), idIsStore (1): producer info; idWbSel 00=addPC, 01=mem, 10=ALU, 11=imm8.
REQ-005 SHALL have inputs freeze (1), the external pipeline hold, and flush (1), a taken branch or jump squashing the decode instruction.
REQ-006 SHALL have outputs fwCntrlA (5) and fwCntrlB (5), registered and presented to the execute stage.
REQ-007 SHALL have output stall (1), combinational, which holds PC and IF/ID and injects a bubble.
REQ-008 SHALL have output stallCnt (16), registered, counting hazard-stall cycles.

Function
REQ-009 SHALL keep two slots: S1, the instruction currently in EX, and S2, the one in MEM; each slot holds {vld, dstWr, dst[2:0], wbSel[1:0]}.
REQ-010 SHALL advance on each clock edge with freeze=0: S2<=S1, and S1<=decode entry when idValid & ~stall & ~flush, else S1<=bubble (vld=0).
REQ-011 SHALL hold S1, S2, fwCntrlA/B and stallCnt unchanged whenever freeze=1.
REQ-012 SHALL treat a source X (A or B) as matching slot Sn iff idSrcXVld & Sn.vld & Sn.dstWr & (Sn.dst==idSrcX).
REQ-013 SHALL encode the control word as: bit3=forward; bit2=0 for EX-to-EX from S1, 1 for MEM-to-EX from S2; bits1:0 = producer wbSel.
REQ-014 SHALL give an S1 match priority over an S2 match, because S1 holds the youngest producer.
REQ-015 SHALL assert stall when any source matches S1 with S1.wbSel=01, the load-use case.
REQ-016 SHALL produce no control word with bit2=0 and bits1:0=01.
REQ-017 SHALL keep stall at 0 when idValid=0 or flush=1.
REQ-018 SHALL set fwCntrlB[4]=1 iff idIsStore & idSrcBVld & (B forwarded); otherwise fwCntrlB[4]=0.
REQ-019 SHALL force fwCntrlA[4]=0 at all times.
REQ-020 SHALL compute fwCntrl words from the decode instruction and register them on advance.
REQ-021 SHALL register 5'b00000 on both fwCntrl outputs when the advance inserts a bubble.
REQ-022 SHALL register 0 in bit3 for a source with no match, meaning the execute stage uses the register-file value.
REQ-023 SHALL increment stallCnt by 1 on each advancing edge where stall=1, saturating at 16'hFFFF.
REQ-024 SHALL, when flush and stall coincide, let flush win: stall=0, S1<=bubble, stallCnt not incremented.
REQ-025 SHALL, when freeze and flush coincide, hold all state; flush takes effect on the first unfrozen edge only if it is still asserted.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear S1.vld, S2.vld, fwCntrlA, fwCntrlB and stallCnt to 0.
REQ-027 SHALL drive stall=0 while rst_n=0 and on the first edge after release, because both slots are empty.
REQ-028 SHALL discard in-flight slot contents when reset is asserted mid-operation; no forwarding to pre-reset producers follows.

Configuration
REQ-029 SHALL use macro FWD_X2X_EN: when defined, S1 matches with wbSel!=01 forward per REQ-013 with bit2=0.
REQ-030 SHALL, when FWD_X2X_EN is undefined, treat every S1 match as a stall per REQ-015, emit only bit2=1 words, and count those stalls in stallCnt.

Verification
REQ-031 SHALL cover: ADD writes r3 (wbSel=10), next instruction reads r3 as A -> fwCntrlA=5'b01010 next cycle, stall=0 (macro defined).
REQ-032 SHALL cover: LD writes r2 (wbSel=01), next instruction reads r2 as B -> stall=1 for one cycle, then fwCntrlB=5'b01101, stallCnt=1.
REQ-033 SHALL cover: ST whose data register r5 was written two ahead by LBI (wbSel=11) -> fwCntrlB=5'b11111.
REQ-034 SHALL cover: r4 written by both S1 (ALU) and S2 (mem), consumer reads r4 -> fwCntrlA=5'b01010 (S1 wins).
REQ-035 SHALL cover: load-use stall with flush asserted in the same cycle -> stall=0, fwCntrl=0 next cycle, stallCnt unchanged.
REQ-036 SHALL cover: rst_n pulsed low mid-stream with a pending S1 match -> fwCntrlA/B=0 and stallCnt=0 immediately; the next dependent instruction is not forwarded.
